fp_div_seq: RTL
===============

# fp_div_seq

Sequential IEEE-754 double-precision divider, the inverse-operation companion to the FP multiplier in the FP functional-unit group. It accepts one operand pair through a valid/ready handshake and runs a radix-2 restoring mantissa division, one quotient bit per cycle. It truncates and normalizes the quotient, packs the result, and holds it with exception flags until the consumer (reservation-station/CDB side) accepts it. One operation is in flight at a time.

## Interface
Parameters
- `QBITS`, 54: quotient bits generated (1 integer bit + 52 fraction + 1 normalization bit).

Ports (one clock; reset is asynchronous and active-high)
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in IDLE.
- `a`  in  64  dividend (IEEE-754 double).
- `b`  in  64  divisor (IEEE-754 double).
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `res`  out  64  quotient (IEEE-754 double).
- `flags`  out  5  {invalid, div_by_zero, overflow, underflow, denorm_in}.

## Operation
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `res`=0, `flags`=0. All internal registers are cleared.
- States:
  - IDLE → DIV on accept, for normal operands.
  - IDLE → NORM on accept, for special operands.
  - DIV → NORM after `QBITS` iterations.
  - NORM → DONE.
  - DONE → IDLE when `out_valid && out_ready`.
- An accept is `in_valid && in_ready` at an edge. On accept, the block latches the operand fields and computes:
  - sign = sa ^ sb.
  - Ediff = ea − eb + 1023, held as 13-bit signed.
  - Remainder R = {1,ma} and divisor D = {1,mb}, each 53 bits plus a guard bit.
- Denormal inputs (e=0, m≠0) are flushed to signed zero before classification, and `denorm_in` is set.
- Special cases, in priority order (result is formed in NORM, no DIV):
  1. Either input NaN, 0/0, or Inf/Inf: `res`=0x7FF8000000000000, `invalid`=1.
  2. Finite nonzero / 0: ±Inf, `div_by_zero`=1.
  3. Inf / finite: ±Inf.
  4. Finite / Inf, or 0 / nonzero: ±0.
- DIV iteration, repeated `QBITS` times: if R ≥ D then q_bit=1 and R←R−D, else q_bit=0. Then R←R<<1 and the bit is shifted into q (MSB first).
- NORM step:
  - If q[53]=1: fraction = q[52:1], E = Ediff.
  - Else: fraction = q[51:0], E = Ediff − 1.
- Rounding is truncation; bits below the retained fraction are discarded.
- Exponent range:
  - E ≥ 2047 gives ±Inf and `overflow`=1.
  - E ≤ 0 gives ±0 and `underflow`=1. There is no denormal output.
- `res` and `flags` are stable while `out_valid`=1.
- `denorm_in` may accompany any other flag.

## Timing
- Normal operand pair:
  - Accept at edge E0.
  - Iterations at E1..E54.
  - NORM at E55, which sets `out_valid`; it is visible the cycle after E55, for a latency of 55 cycles.
- Special operand pair: NORM at E1, with `out_valid` after E1.
- `out_valid` drops at the edge where `out_ready` is sampled high.
- `in_ready` goes high the cycle after that edge. Completion and a new accept never happen in the same cycle.
- `out_ready` held high before `out_valid` rises: the result still appears for one cycle.
- Reset asserted mid-DIV or in DONE: the operation is aborted immediately, the result is discarded, and outputs return to their reset values.
- `in_valid` while busy is ignored; operands are sampled only on accept.

## Structure
- Package `fp_div_pkg`:
  - constants BIAS=1023, EXP_MAX=2047, QNAN=64'h7FF8000000000000.
  - state enum {IDLE, DIV, NORM, DONE}.
  - flag bit indices.
- Sub-module `div_step`: one combinational restoring step, taking (R, D) and producing (q_bit, R_next).
- Sub-module `div_classify`: special-case classification, matching the multiplier's validity semantics.
- A 6-bit iteration counter tracks DIV progress.

## Test plan
- 0x4018000000000000 / 0x4000000000000000 (6/2) → `res`=0x4008000000000000, `flags`=0, `out_valid` exactly 55 cycles after accept. Repeat with the dividend sign set → 0xC008000000000000.
- 0x3FF0000000000000 / 0x4008000000000000 (1/3) → 0x3FD5555555555555 (q[53]=0 path).
- 0x3FF0000000000000 / 0 → 0x7FF0000000000000 with `div_by_zero`. 0/0 → 0x7FF8000000000000 with `invalid`. Both valid after 1 cycle.
- 0x7FE0000000000000 / 0x3FE0000000000000 → 0x7FF0000000000000 with `overflow`. 0x0010000000000000 / 0x4000000000000000 → 0 with `underflow`.
- `out_ready` held low for 10 cycles after `out_valid` → `res` stable and `in_ready`=0 throughout. `in_valid` pulsed during DIV has no effect.
- `rst` pulsed at iteration 20 → `out_valid`=0 and `in_ready`=1 immediately. A new 6/2 operation afterwards completes correctly.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential double-precision divider.
// States, IEEE-754 constants and flag bit positions.
package fp_div_pkg;

  localparam int BIAS    = 1023;
  localparam int EXP_MAX = 2047;

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  // Width of the remainder/divisor datapath: 1 guard + 1 hidden + 52
  localparam int RW = 54;

  // Flag vector positions: {invalid, div_by_zero, overflow, underflow, denorm_in}
  localparam int F_INV = 4;
  localparam int F_DBZ = 3;
  localparam int F_OVF = 2;
  localparam int F_UNF = 1;
  localparam int F_DEN = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [63:0] fp_inf(input logic s);
    return {s, 11'h7FF, 52'h0};
  endfunction

  function automatic logic [63:0] fp_zero(input logic s);
    return {s, 63'h0};
  endfunction

endpackage

// File: rtl/div_classify.sv
// Operand classification for division: flushes denormals to zero
// and resolves NaN/Inf/zero cases to a fixed result and flags.
module div_classify
  import fp_div_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        special_o,
  output logic [63:0] res_o,
  output logic        inv_o,
  output logic        dbz_o,
  output logic        den_o
);

  logic       s;
  logic       a_den, b_den;
  logic       a_zero, b_zero;
  logic       a_inf, b_inf;
  logic       a_nan, b_nan;

  // Field decode; a zero exponent is zero once denormals are flushed
  always_comb begin
    s      = a_i[63] ^ b_i[63];
    a_den  = (a_i[62:52] == 11'h0) && (a_i[51:0] != 52'h0);
    b_den  = (b_i[62:52] == 11'h0) && (b_i[51:0] != 52'h0);
    a_zero = (a_i[62:52] == 11'h0);
    b_zero = (b_i[62:52] == 11'h0);
    a_inf  = (a_i[62:52] == 11'h7FF) && (a_i[51:0] == 52'h0);
    b_inf  = (b_i[62:52] == 11'h7FF) && (b_i[51:0] == 52'h0);
    a_nan  = (a_i[62:52] == 11'h7FF) && (a_i[51:0] != 52'h0);
    b_nan  = (b_i[62:52] == 11'h7FF) && (b_i[51:0] != 52'h0);
  end

  // Priority-ordered special-case resolution
  always_comb begin
    special_o = 1'b1;
    res_o     = 64'h0;
    inv_o     = 1'b0;
    dbz_o     = 1'b0;
    den_o     = a_den | b_den;
    if (a_nan || b_nan || (a_zero && b_zero) ||
        (a_inf && b_inf)) begin
      res_o = QNAN;
      inv_o = 1'b1;
    end else if (b_zero && !a_inf) begin
      res_o = fp_inf(s);
      dbz_o = 1'b1;
    end else if (a_inf) begin
      res_o = fp_inf(s);
    end else if (b_inf || a_zero) begin
      res_o = fp_zero(s);
    end else begin
      special_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_step.sv
// One restoring division step: compare, conditionally subtract,
// then shift the partial remainder left by one.
module div_step #(
  parameter int W = 54
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] d_i,
  output logic         q_o,
  output logic [W-1:0] r_o
);

  logic [W-1:0] diff;
  logic [W-1:0] sel;

  // Remainder stays below 2*D, so the shifted top bit is always zero
  always_comb begin
    diff = r_i - d_i;
    q_o  = (r_i >= d_i);
    sel  = q_o ? diff : r_i;
    r_o  = sel << 1;
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 double divider, one quotient bit per cycle.
// Truncating, flush-to-zero, single operation in flight.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int QBITS = 54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] res,
  output logic [4:0]  flags
);

  localparam logic [5:0] LAST = 6'(QBITS - 1);
  localparam logic signed [12:0] EBIAS = 13'(BIAS);
  localparam logic signed [12:0] EMAX  = 13'(EXP_MAX);

  state_t             state_q;
  logic [5:0]         cnt_q;
  logic [RW-1:0]      r_q;
  logic [RW-1:0]      d_q;
  logic [QBITS-1:0]   q_q;
  logic signed [12:0] ediff_q;
  logic               sign_q;
  logic               special_q;
  logic [63:0]        sp_res_q;
  logic               inv_q, dbz_q, den_q;
  logic [63:0]        res_q;
  logic [4:0]         flags_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic               accept;
  logic               step_q;
  logic [RW-1:0]      r_d;
  logic [QBITS-1:0]   q_d;
  logic signed [12:0] ediff_d;

  logic               cls_special;
  logic [63:0]        cls_res;
  logic               cls_inv, cls_dbz, cls_den;

  logic signed [12:0] e_n;
  logic [51:0]        frac_n;
  logic [63:0]        norm_res;
  logic               ovf_n, unf_n;
  logic [4:0]         flags_d;

  div_classify u_cls (
    .a_i       (a),
    .b_i       (b),
    .special_o (cls_special),
    .res_o     (cls_res),
    .inv_o     (cls_inv),
    .dbz_o     (cls_dbz),
    .den_o     (cls_den)
  );

  div_step #(.W(RW)) u_step (
    .r_i (r_q),
    .d_i (d_q),
    .q_o (step_q),
    .r_o (r_d)
  );

  // Accept qualifier, quotient shift-in and biased exponent difference
  always_comb begin
    accept  = in_valid && in_ready_q;
    q_d     = {q_q[QBITS-2:0], step_q};
    ediff_d = $signed({2'b00, a[62:52]})
            - $signed({2'b00, b[62:52]}) + EBIAS;
  end

  // Normalize the raw quotient and clamp the exponent range
  always_comb begin
    e_n      = q_q[QBITS-1] ? ediff_q : ediff_q - 13'sd1;
    frac_n   = q_q[QBITS-1] ? q_q[QBITS-2 -: 52]
                            : q_q[QBITS-3 -: 52];
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    norm_res = {sign_q, e_n[10:0], frac_n};
    if (e_n >= EMAX) begin
      norm_res = fp_inf(sign_q);
      ovf_n    = 1'b1;
    end else if (e_n <= 13'sd0) begin
      norm_res = fp_zero(sign_q);
      unf_n    = 1'b1;
    end
  end

  // Final flag vector; range flags only apply to computed quotients
  always_comb begin
    flags_d        = 5'h0;
    flags_d[F_INV] = inv_q;
    flags_d[F_DBZ] = dbz_q;
    flags_d[F_OVF] = ovf_n && !special_q;
    flags_d[F_UNF] = unf_n && !special_q;
    flags_d[F_DEN] = den_q;
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      r_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      ediff_q     <= '0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      sp_res_q    <= 64'h0;
      inv_q       <= 1'b0;
      dbz_q       <= 1'b0;
      den_q       <= 1'b0;
      res_q       <= 64'h0;
      flags_q     <= 5'h0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            sign_q     <= a[63] ^ b[63];
            ediff_q    <= ediff_d;
            r_q        <= {2'b01, a[51:0]};
            d_q        <= {2'b01, b[51:0]};
            q_q        <= '0;
            cnt_q      <= 6'd0;
            special_q  <= cls_special;
            sp_res_q   <= cls_res;
            inv_q      <= cls_inv;
            dbz_q      <= cls_dbz;
            den_q      <= cls_den;
            state_q    <= cls_special ? NORM : DIV;
          end
        end
        DIV: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          res_q       <= special_q ? sp_res_q : norm_res;
          flags_q     <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;

endmodule
